fpu_operand_loader: RTL and testbench
=====================================

Name: fpu_operand_loader

Overview:
- Upstream stage of the FPU in the Tiny Tapeout top.
- Assembles byte-wide host writes into one FPU request: one opcode byte, then operand A (4 bytes, LSB first), then operand B (4 bytes, LSB first).
- The byte strobe comes from an asynchronous pad, so it is synchronised and edge-detected inside the block.
- The completed request is presented to the FPU core through a valid/ready handshake.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in the byte_stb synchroniser (minimum 2).
- TIMEOUT_CYC, 24'd10_000_000: mid-frame idle limit in clk cycles (1 s at 10 MHz). Used only with FPU_LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (10 MHz)
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; when low, strobes are ignored and all state is held
- byte_in  in  8  host data byte (ui_in)
- byte_stb  in  1  asynchronous host strobe; a rising edge means "byte_in valid" (uio_in[0])
- frame_clr  in  1  synchronous abort; returns the block to IDLE
- op_ready  in  1  FPU accepts a request
- op_valid  out  1  request valid
- opcode  out  3  FPU operation
- op_a  out  32  operand A
- op_b  out  32  operand B
- busy  out  1  high in any state other than IDLE
- byte_cnt  out  4  bytes accepted in the current frame (0..9)
- err_overrun  out  1  sticky: a strobe arrived while in PRESENT

Behaviour:
- Reset (async assert, sync-deasserted by top): state=IDLE; all outputs 0; synchroniser flops 0.
- Strobe path:
  - byte_stb passes through SYNC_STAGES flops, then one edge-detect flop.
  - stb_pulse = sync_out & ~prev, i.e. one cycle per rising edge.
  - Latency from pad edge to pulse: SYNC_STAGES+1 cycles.
  - byte_in is sampled in the stb_pulse cycle. The host keeps byte_in stable for at least SYNC_STAGES+2 cycles after raising byte_stb.
- FSM (only advances when ena=1):
  - IDLE: on stb_pulse, opcode<=byte_in[2:0]; byte_in[7:3] ignored; byte_cnt<=1; err_overrun<=0; go to LOAD_A.
  - LOAD_A: each stb_pulse writes byte_in into op_a[8*k+:8], k=byte_cnt-1; byte_cnt++. After the 4th byte (byte_cnt becomes 5), go to LOAD_B.
  - LOAD_B: same as LOAD_A, writing op_b. After byte_cnt becomes 9, go to PRESENT and set op_valid=1 in the same edge.
  - PRESENT:
    - op_valid=1; opcode/op_a/op_b stable.
    - On op_valid&op_ready: op_valid<=0, byte_cnt<=0, go to IDLE. Transfer takes one cycle; op_ready may already be high on entry.
    - stb_pulse in PRESENT: byte dropped, err_overrun<=1.
- frame_clr=1 in any state:
  - Next state IDLE; op_valid<=0; byte_cnt<=0.
  - op_a/op_b/opcode keep their last values; err_overrun unchanged.
  - frame_clr has priority over stb_pulse and over the handshake in the same cycle.
- ena=0 for one cycle: state, counters and the edge-detect register are frozen, so an edge seen during ena=0 is lost. op_valid is held; a handshake completes only if ena=1.
- Latency: last B byte stb_pulse to op_valid = 1 cycle (registered).
- Reset mid-frame: everything returns to reset values immediately.

Optional Feature:
- Macro: FPU_LOADER_TIMEOUT_EN.
- Defined:
  - Adds a 24-bit idle counter, cleared on every stb_pulse, counting only in LOAD_A/LOAD_B.
  - Reaching TIMEOUT_CYC-1 forces IDLE and byte_cnt=0, and pulses output err_timeout high for one cycle.
  - The port err_timeout (out, 1) exists only when the macro is defined.
- Undefined: no counter and no err_timeout port; a partial frame waits indefinitely.

Decomposition:
- Package fpu_pkg:
  - fpu_op_e: 3-bit opcode enum (ADD=0, SUB=1, MUL=2, DIV=3, CMP=4, reserved 5-7).
  - Loader state enum: IDLE, LOAD_A, LOAD_B, PRESENT.
  - Constants: FRAME_BYTES=9, OPERAND_BYTES=4.
- Sub-module stb_sync_edge (parameter SYNC_STAGES): synchroniser plus rising-edge detector, output stb_pulse; reused by other pad inputs.

Test Plan:
- Normal frame: bytes 0x02, 0x00,0x00,0x80,0x3F, 0x00,0x00,0x00,0x40 with op_ready=1 -> opcode=2, op_a=0x3F800000, op_b=0x40000000; op_valid high exactly 1 cycle; busy returns to 0.
- Backpressure: same frame with op_ready=0 for 20 cycles -> op_valid and operands stable for all 20 cycles; extra strobe sets err_overrun=1; next opcode byte clears it.
- Abort: frame_clr after 3 bytes -> byte_cnt=0, busy=0; next full frame 0x01, A=0x11223344, B=0x55667788 -> op_a=0x11223344, op_b=0x55667788.
- Strobe timing: byte_stb held high 50 cycles -> exactly one byte accepted; pulse appears SYNC_STAGES+1 cycles after the edge.
- ena=0 across a strobe edge -> byte not counted and byte_cnt unchanged; async rst_n low mid-LOAD_B -> all outputs 0 immediately.
- FPU_LOADER_TIMEOUT_EN with TIMEOUT_CYC=100: stop after 2 bytes -> err_timeout pulses at cycle 100, state returns to IDLE.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types: opcode encoding, operand-loader state encoding and frame geometry.
package fpu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    CMP = 3'd4
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    PRESENT
  } ldr_state_e;

  localparam int FRAME_BYTES   = 9;
  localparam int OPERAND_BYTES = 4;

endpackage

// File: rtl/stb_sync_edge.sv
// Pad-input synchroniser followed by a rising-edge detector; one-cycle pulse per rising edge.
module stb_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // The synchroniser free-runs; only the edge-detect history honours ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      if (ena) prev <= sync[SYNC_STAGES-1];
    end
  end

  assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/fpu_operand_loader.sv
// Assembles opcode + two 32-bit operands from strobed host bytes into one FPU request.
// Optional mid-frame idle timeout enabled by defining FPU_LOADER_TIMEOUT_EN.
module fpu_operand_loader
  import fpu_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  byte_in,
  input  logic        byte_stb,
  input  logic        frame_clr,
  input  logic        op_ready,
  output logic        op_valid,
  output logic [2:0]  opcode,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        busy,
  output logic [3:0]  byte_cnt,
  output logic        err_overrun
`ifdef FPU_LOADER_TIMEOUT_EN
  ,
  output logic        err_timeout
`endif
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYC < 24'd2) begin : g_param_check
    $error("fpu_operand_loader: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 2");
  end

  ldr_state_e state, state_nxt;
  fpu_op_e    op_q;
  logic [3:0] cnt_nxt;
  logic       valid_nxt, ovr_nxt;
  logic       ld_op, ld_a, ld_b;
  logic       stb_pulse, timeout_hit;
  logic [1:0] lane;

  stb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stb (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .din   (byte_stb),
    .pulse (stb_pulse)
  );

  // Byte counts 1..4 map to lanes 0..3 for A, and 5..8 wrap to the same lanes for B.
  assign lane   = byte_cnt[1:0] - 2'd1;
  assign busy   = (state != IDLE);
  assign opcode = op_q;

`ifdef FPU_LOADER_TIMEOUT_EN
  logic [23:0] idle_cnt;
  logic        loading;

  assign loading     = (state == LOAD_A) || (state == LOAD_B);
  assign timeout_hit = ena & loading & ~stb_pulse & ~frame_clr &
                       (idle_cnt == TIMEOUT_CYC - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
      if (ena) begin
        if (stb_pulse || !loading || timeout_hit || frame_clr) idle_cnt <= '0;
        else                                                   idle_cnt <= idle_cnt + 24'd1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = byte_cnt;
    valid_nxt = op_valid;
    ovr_nxt   = err_overrun;
    ld_op     = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    if (ena) begin
      if (frame_clr || timeout_hit) begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        cnt_nxt   = '0;
      end else begin
        unique case (state)
          IDLE: if (stb_pulse) begin
            ld_op     = 1'b1;
            cnt_nxt   = 4'd1;
            ovr_nxt   = 1'b0;
            state_nxt = LOAD_A;
          end
          LOAD_A: if (stb_pulse) begin
            ld_a    = 1'b1;
            cnt_nxt = byte_cnt + 4'd1;
            if (cnt_nxt == 4'(OPERAND_BYTES + 1)) state_nxt = LOAD_B;
          end
          LOAD_B: if (stb_pulse) begin
            ld_b    = 1'b1;
            cnt_nxt = byte_cnt + 4'd1;
            if (cnt_nxt == 4'(FRAME_BYTES)) begin
              state_nxt = PRESENT;
              valid_nxt = 1'b1;
            end
          end
          PRESENT: begin
            if (stb_pulse) ovr_nxt = 1'b1;
            if (op_valid && op_ready) begin
              valid_nxt = 1'b0;
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      op_valid    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      byte_cnt    <= cnt_nxt;
      op_valid    <= valid_nxt;
      err_overrun <= ovr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= ADD;
      op_a <= '0;
      op_b <= '0;
    end else begin
      if (ld_op) op_q <= fpu_op_e'(byte_in[2:0]);
      if (ld_a)  op_a[8*lane +: 8] <= byte_in;
      if (ld_b)  op_b[8*lane +: 8] <= byte_in;
    end
  end

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Scoreboard bench for fpu_operand_loader: frames queued on send, checked on handshake.
module tb_fpu_operand_loader;

  localparam int SYNC = 2;
`ifdef FPU_LOADER_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 10_000_000;
`endif

  logic        clk = 1'b0;
  logic        rst_n, ena, byte_stb, frame_clr, op_ready;
  logic [7:0]  byte_in;
  logic        op_valid, busy, err_overrun;
  logic [2:0]  opcode;
  logic [31:0] op_a, op_b;
  logic [3:0]  byte_cnt;
`ifdef FPU_LOADER_TIMEOUT_EN
  logic        err_timeout;
`endif

  fpu_operand_loader #(.SYNC_STAGES(SYNC), .TIMEOUT_CYC(24'(TO))) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .byte_in     (byte_in),
    .byte_stb    (byte_stb),
    .frame_clr   (frame_clr),
    .op_ready    (op_ready),
    .op_valid    (op_valid),
    .opcode      (opcode),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .byte_cnt    (byte_cnt),
    .err_overrun (err_overrun)
`ifdef FPU_LOADER_TIMEOUT_EN
    ,
    .err_timeout (err_timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } frame_t;

  frame_t sb_q[$];
  int     checks = 0;
  int     errors = 0;
  int     vrun = 0;
  int     last_vrun = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in  = b;
    byte_stb = 1'b1;
    tick(SYNC + 3);
    byte_stb = 1'b0;
    tick(SYNC + 3);
  endtask

  task automatic send_frame(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    sb_q.push_back('{op: op, a: a, b: b});
    send_byte({5'b10101, op});
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
  endtask

  // Handshake monitor: pops the oldest expected frame on every transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (op_valid) vrun++;
      else if (vrun != 0) begin
        last_vrun = vrun;
        vrun      = 0;
      end
      if (op_valid && op_ready && ena && !frame_clr) begin
        if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        else begin
          frame_t f;
          f = sb_q.pop_front();
          chk("hs_opcode", 32'(opcode), 32'(f.op));
          chk("hs_op_a", op_a, f.a);
          chk("hs_op_b", op_b, f.b);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok;
    int          lat;
    logic [31:0] ra, rb;
    rst_n = 1'b0; ena = 1'b1; byte_stb = 1'b0; frame_clr = 1'b0;
    op_ready = 1'b1; byte_in = 8'h00;
    tick(3);
    chk("rst_valid", 32'(op_valid), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_busy_cnt_ovr", 32'({busy, byte_cnt, err_overrun}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Normal frame with the consumer always ready.
    send_frame(3'd2, 32'h3F80_0000, 32'h4000_0000);
    chk("norm_valid_len", 32'(last_vrun), 32'd1);
    chk("norm_busy", 32'(busy), 32'd0);
    chk("norm_cnt", 32'(byte_cnt), 32'd0);
    chk("norm_sb_drained", 32'(sb_q.size()), 32'd0);

    // Backpressure, then an overrun strobe while presenting.
    op_ready = 1'b0;
    send_frame(3'd2, 32'h3F80_0000, 32'h4000_0000);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok &= op_valid & (opcode == 3'd2) & (op_a == 32'h3F80_0000) & (op_b == 32'h4000_0000);
      tick(1);
    end
    chk("bp_stable", 32'(ok), 32'd1);
    chk("bp_cnt", 32'(byte_cnt), 32'd9);
    send_byte(8'hEE);
    chk("ovr_set", 32'(err_overrun), 32'd1);
    chk("ovr_valid_held", 32'(op_valid), 32'd1);
    chk("ovr_op_b_kept", op_b, 32'h4000_0000);
    op_ready = 1'b1;
    tick(3);
    chk("bp_released", 32'(op_valid), 32'd0);
    chk("bp_sb_drained", 32'(sb_q.size()), 32'd0);
    chk("ovr_sticky", 32'(err_overrun), 32'd1);
    send_byte(8'hFC);
    chk("ovr_cleared", 32'(err_overrun), 32'd0);
    chk("op_masked", 32'(opcode), 32'd4);

    // Abort after three bytes; operands keep their partial contents.
    send_byte(8'h11);
    send_byte(8'h22);
    chk("abort_pre_cnt", 32'(byte_cnt), 32'd3);
    frame_clr = 1'b1;
    tick(1);
    frame_clr = 1'b0;
    tick(1);
    chk("abort_cnt", 32'(byte_cnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_opcode_kept", 32'(opcode), 32'd4);
    chk("abort_op_a_kept", {16'h0, op_a[15:0]}, 32'h0000_2211);
    send_frame(3'd1, 32'h1122_3344, 32'h5566_7788);
    chk("post_abort_drained", 32'(sb_q.size()), 32'd0);

    // Long strobe: one byte only, accepted SYNC+1 edges after the pad edge.
    byte_in  = 8'h03;
    byte_stb = 1'b1;
    lat = 0;
    while (byte_cnt == 4'd0 && lat < 20) begin
      tick(1);
      lat++;
    end
    chk("stb_latency", 32'(lat), 32'(SYNC + 1));
    tick(50 - lat);
    byte_stb = 1'b0;
    tick(10);
    chk("stb_held_one_byte", 32'(byte_cnt), 32'd1);

    // A whole strobe inside an ena=0 window is lost.
    ena      = 1'b0;
    byte_in  = 8'h44;
    byte_stb = 1'b1;
    tick(6);
    byte_stb = 1'b0;
    tick(6);
    ena = 1'b1;
    tick(6);
    chk("ena_lost_cnt", 32'(byte_cnt), 32'd1);
    chk("ena_lost_busy", 32'(busy), 32'd1);

    // Asynchronous reset in the middle of LOAD_B.
    for (int i = 0; i < 6; i++) send_byte(8'h90 + 8'(i));
    chk("mid_b_cnt", 32'(byte_cnt), 32'd7);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt_busy", 32'({busy, byte_cnt}), 32'd0);
    chk("arst_op_a", op_a, 32'd0);
    chk("arst_op_b_op", {op_b[28:0], opcode}, 32'd0);
    chk("arst_flags", 32'({op_valid, err_overrun}), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    ra = $urandom;
    rb = $urandom;
    send_frame(3'($urandom_range(0, 7)), ra, rb);
    chk("rand_sb_drained", 32'(sb_q.size()), 32'd0);

`ifdef FPU_LOADER_TIMEOUT_EN
    // Stall after two bytes and wait for the idle timeout.
    send_byte(8'h02);
    send_byte(8'h55);
    lat = 0;
    while (!err_timeout && lat < 300) begin
      tick(1);
      lat++;
    end
    chk("to_seen", 32'(err_timeout), 32'd1);
    chk("to_window", 32'(lat >= 85 && lat <= 105), 32'd1);
    tick(1);
    chk("to_one_cycle", 32'(err_timeout), 32'd0);
    chk("to_idle", 32'({busy, byte_cnt}), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
